// File: rtl/regfile_sb_pkg.sv
// regfile_pkg: FSM states and sizing helper shared by the register file blocks
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic int num_regs(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the register file
interface regfile_sb_if #(parameter int DATA_W = 16, parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, issue_addr;
  logic [DATA_W-1:0] rd_data1, rd_data2, wr_data;
  logic rd_pend1, rd_pend2, wr_en, issue_en, clr_req, busy;
  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr, clr_req,
    input  rd_data1, rd_data2, rd_pend1, rd_pend2, busy
  );
  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr, clr_req,
    output rd_data1, rd_data2, rd_pend1, rd_pend2, busy
  );
endinterface

// File: rtl/regfile_sb_rf_bank.sv
// rf_bank: register storage with one synchronous write port and two async read ports
module rf_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);
  localparam int NUM_REGS = num_regs(ADDR_W);
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R1W register file with bypass, optional zero register,
// pending-writeback scoreboard and a one-register-per-cycle bulk clear
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NUM_REGS = num_regs(ADDR_W);
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [NUM_REGS-1:0] r_pend;
  logic                w_busy, w_wr_ok, w_iss_ok, w_zero1, w_zero2, w_byp1, w_byp2;
  logic [DATA_W-1:0]   w_bank1, w_bank2;
  assign w_busy   = r_state == CLEAR;
  assign w_wr_ok  = bus.wr_en && !w_busy && !(ZERO_REG && bus.wr_addr == '0);
  assign w_iss_ok = bus.issue_en && !w_busy && !(ZERO_REG && bus.issue_addr == '0);
  assign w_zero1  = ZERO_REG && bus.rd_addr1 == '0;
  assign w_zero2  = ZERO_REG && bus.rd_addr2 == '0;
  assign w_byp1   = BYPASS && w_wr_ok && bus.wr_addr == bus.rd_addr1;
  assign w_byp2   = BYPASS && w_wr_ok && bus.wr_addr == bus.rd_addr2;
  // the clear sequencer borrows the single write port while busy
  rf_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_busy || w_wr_ok),
    .i_waddr  (w_busy ? r_cnt : bus.wr_addr),
    .i_wdata  (w_busy ? '0 : bus.wr_data),
    .i_raddr1 (bus.rd_addr1),
    .i_raddr2 (bus.rd_addr2),
    .o_rdata1 (w_bank1),
    .o_rdata2 (w_bank2)
  );
  assign bus.rd_data1 = w_zero1 ? '0 : w_byp1 ? bus.wr_data : w_bank1;
  assign bus.rd_data2 = w_zero2 ? '0 : w_byp2 ? bus.wr_data : w_bank2;
  // a same-cycle writeback hides the pending bit unless an issue re-marks it
  assign bus.rd_pend1 = !w_busy && !w_zero1 && r_pend[bus.rd_addr1] &&
                        !(w_byp1 && !(w_iss_ok && bus.issue_addr == bus.rd_addr1));
  assign bus.rd_pend2 = !w_busy && !w_zero2 && r_pend[bus.rd_addr2] &&
                        !(w_byp2 && !(w_iss_ok && bus.issue_addr == bus.rd_addr2));
  assign bus.busy = w_busy;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && bus.clr_req) w_next = CLEAR;
    if (r_state == CLEAR && &r_cnt) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_next;
      if (w_busy) r_cnt <= r_cnt + 1'b1;
      else if (bus.clr_req) r_cnt <= '0;
      if (!w_busy && bus.clr_req) r_pend <= '0;
      else begin
        if (w_wr_ok) r_pend[bus.wr_addr] <= 1'b0;
        if (w_iss_ok) r_pend[bus.issue_addr] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of read/bypass, scoreboard, zero register and bulk clear
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) zb ();
  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_z (
    .clk(clk), .rst(rst), .bus(zb));

  task automatic idle_inputs;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.issue_en = 0; bus.issue_addr = 0;
    bus.clr_req = 0; bus.rd_addr1 = 0; bus.rd_addr2 = 0;
    zb.wr_en = 0; zb.wr_addr = 0; zb.wr_data = 0; zb.issue_en = 0; zb.issue_addr = 0;
    zb.clr_req = 0; zb.rd_addr1 = 0; zb.rd_addr2 = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || zb.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: busy=%b/%b exp 0", bus.busy, zb.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.rd_addr1 = 4'(i); bus.rd_addr2 = 4'(15 - i);
      #1;
      n_tests++;
      if ({bus.rd_data1, bus.rd_data2, bus.rd_pend1, bus.rd_pend2} !== 34'h0) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: d1=%h d2=%h p1=%b p2=%b exp all 0",
                 i, bus.rd_data1, bus.rd_data2, bus.rd_pend1, bus.rd_pend2);
      end
    end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 16'hBEEF; bus.rd_addr1 = 5;
    #1;
    n_tests++;
    if (bus.rd_data1 !== 16'hBEEF) begin
      n_fail++; $display("FAIL bypass_same: rd_data1=%h exp beef", bus.rd_data1);
    end
    @(negedge clk);
    bus.wr_en = 0;
    #1;
    n_tests++;
    if (bus.rd_data1 !== 16'hBEEF) begin
      n_fail++; $display("FAIL bypass_stored: rd_data1=%h exp beef", bus.rd_data1);
    end
    bus.wr_data = 16'h1234;
    #1;
    n_tests++;
    if (bus.rd_data1 !== 16'hBEEF) begin
      n_fail++; $display("FAIL bypass_no_en: rd_data1=%h exp beef", bus.rd_data1);
    end
    @(negedge clk);
    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 16'hA5A5;
    @(negedge clk);
    bus.wr_en = 0; bus.rd_addr2 = 0;
    #1;
    n_tests++;
    if (bus.rd_data2 !== 16'hA5A5) begin
      n_fail++; $display("FAIL r0_plain: rd_data2=%h exp a5a5", bus.rd_data2);
    end
  endtask

  task automatic test_pending;
    @(negedge clk);
    bus.issue_en = 1; bus.issue_addr = 3; bus.rd_addr2 = 3; bus.rd_addr1 = 4;
    @(negedge clk);
    bus.issue_en = 0;
    #1;
    n_tests++;
    if (bus.rd_pend2 !== 1'b1 || bus.rd_pend1 !== 1'b0) begin
      n_fail++; $display("FAIL pend_issue: p2=%b p1=%b exp 1 0", bus.rd_pend2, bus.rd_pend1);
    end
    @(negedge clk);
    bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 16'h0042;
    #1;
    n_tests++;
    if (bus.rd_pend2 !== 1'b0 || bus.rd_data2 !== 16'h0042) begin
      n_fail++; $display("FAIL pend_wb: p2=%b d2=%h exp 0 0042", bus.rd_pend2, bus.rd_data2);
    end
    @(negedge clk);
    bus.wr_en = 0;
    #1;
    n_tests++;
    if (bus.rd_pend2 !== 1'b0 || bus.rd_data2 !== 16'h0042) begin
      n_fail++; $display("FAIL pend_after_wb: p2=%b d2=%h exp 0 0042", bus.rd_pend2, bus.rd_data2);
    end
    @(negedge clk);
    bus.wr_en = 1; bus.wr_data = 16'h0077; bus.issue_en = 1; bus.issue_addr = 3;
    @(negedge clk);
    bus.wr_en = 0; bus.issue_en = 0;
    #1;
    n_tests++;
    if (bus.rd_pend2 !== 1'b1 || bus.rd_data2 !== 16'h0077) begin
      n_fail++; $display("FAIL pend_issue_wins: p2=%b d2=%h exp 1 0077", bus.rd_pend2, bus.rd_data2);
    end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    zb.wr_en = 1; zb.wr_addr = 0; zb.wr_data = 16'hFFFF;
    zb.issue_en = 1; zb.issue_addr = 0; zb.rd_addr1 = 0; zb.rd_addr2 = 0;
    #1;
    n_tests++;
    if (zb.rd_data1 !== 16'h0000 || zb.rd_pend1 !== 1'b0) begin
      n_fail++; $display("FAIL zero_same: d1=%h p1=%b exp 0000 0", zb.rd_data1, zb.rd_pend1);
    end
    @(negedge clk);
    zb.wr_en = 0; zb.issue_en = 0;
    #1;
    n_tests++;
    if (zb.rd_data2 !== 16'h0000 || zb.rd_pend2 !== 1'b0) begin
      n_fail++; $display("FAIL zero_after: d2=%h p2=%b exp 0000 0", zb.rd_data2, zb.rd_pend2);
    end
    @(negedge clk);
    zb.wr_en = 1; zb.wr_addr = 1; zb.wr_data = 16'h1111; zb.rd_addr1 = 1;
    #1;
    n_tests++;
    if (zb.rd_data1 !== 16'h1111) begin
      n_fail++; $display("FAIL zero_r1_bypass: d1=%h exp 1111", zb.rd_data1);
    end
    @(negedge clk);
    zb.wr_en = 0;
  endtask

  task automatic test_bulk_clear;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.wr_en = 1; bus.wr_addr = 4'(i); bus.wr_data = 16'(16'h1001 + i);
    end
    @(negedge clk);
    bus.wr_en = 0; bus.issue_en = 1; bus.issue_addr = 9;
    @(negedge clk);
    bus.issue_en = 0; bus.rd_addr1 = 9; bus.clr_req = 1;
    #1;
    n_tests++;
    if (bus.rd_pend1 !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_pre: p1=%b busy=%b exp 1 0", bus.rd_pend1, bus.busy);
    end
    for (int j = 0; j < 16; j++) begin
      logic [15:0] exp2;
      @(negedge clk);
      bus.clr_req = 0;
      bus.wr_en = (j == 3); bus.wr_addr = 12; bus.wr_data = 16'hDEAD;
      bus.issue_en = (j == 3); bus.issue_addr = 12;
      bus.rd_addr1 = 4'(j); bus.rd_addr2 = 4'(j - 1);
      exp2 = (j == 0) ? 16'h1010 : 16'h0000;
      #1;
      n_tests++;
      if (bus.busy !== 1'b1 || bus.rd_data1 !== 16'(16'h1001 + j) || bus.rd_data2 !== exp2) begin
        n_fail++;
        $display("FAIL clr_step[%0d]: busy=%b d1=%h d2=%h exp 1 %h %h",
                 j, bus.busy, bus.rd_data1, bus.rd_data2, 16'(16'h1001 + j), exp2);
      end
      if (j == 3) begin
        bus.rd_addr2 = 12;
        #1;
        n_tests++;
        if (bus.rd_data2 !== 16'h100D || bus.rd_pend2 !== 1'b0) begin
          n_fail++; $display("FAIL clr_no_bypass: d2=%h p2=%b exp 100d 0", bus.rd_data2, bus.rd_pend2);
        end
      end
    end
    @(negedge clk);
    bus.wr_en = 0; bus.issue_en = 0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_done: busy=%b exp 0", bus.busy);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.rd_addr1 = 4'(i);
      #1;
      n_tests++;
      if (bus.rd_data1 !== 16'h0000 || bus.rd_pend1 !== 1'b0) begin
        n_fail++; $display("FAIL clr_final[%0d]: d1=%h p1=%b exp 0000 0", i, bus.rd_data1, bus.rd_pend1);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    @(negedge clk); bus.wr_en = 1; bus.wr_addr = 7;  bus.wr_data = 16'h7777;
    @(negedge clk); bus.wr_addr = 10; bus.wr_data = 16'hAAAA;
    @(negedge clk); bus.wr_addr = 14; bus.wr_data = 16'hEEEE;
    @(negedge clk); bus.wr_en = 0; bus.clr_req = 1;
    @(negedge clk); bus.clr_req = 0;
    repeat (7) @(negedge clk);
    bus.rd_addr1 = 6; bus.rd_addr2 = 7;
    #1;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.rd_data1 !== 16'h0000 || bus.rd_data2 !== 16'h7777) begin
      n_fail++;
      $display("FAIL mid_clear: busy=%b d1=%h d2=%h exp 1 0000 7777", bus.busy, bus.rd_data1, bus.rd_data2);
    end
    #1 rst = 1'b1;
    bus.rd_addr1 = 10; bus.rd_addr2 = 14;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.rd_data1 !== 16'h0000 || bus.rd_data2 !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_rst: busy=%b d1=%h d2=%h exp 0 0000 0000", bus.busy, bus.rd_data1, bus.rd_data2);
    end
    #1 rst = 1'b0;
    bus.clr_req = 1;
    @(negedge clk);
    bus.clr_req = 0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_after_rst: busy=%b exp 1", bus.busy);
    end
    for (int c = 0; c < 40 && bus.busy; c++) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_timeout: busy=%b exp 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_pending();
    test_zero_reg();
    test_bulk_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
